// File: rtl/ima_adpcm_decoder_mc_if.sv
// Handshake bundle for the multi-channel IMA ADPCM decoder: code input,
// header preload, and decoded sample output.
// Optional status signals (out_sat, err_ch) exist only with ADPCM_STATUS_EN.
interface ima_adpcm_decoder_mc_if #(
  parameter int NUM_CH = 4,
  parameter int OUT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic              in_sop;
  logic [3:0]        in_code;
  logic              load_en;
  logic [CH_W-1:0]   load_ch;
  logic [15:0]       load_pred;
  logic [6:0]        load_index;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [OUT_W-1:0]  out_sample;
`ifdef ADPCM_STATUS_EN
  logic              out_sat;
  logic              err_ch;
`endif

`ifdef ADPCM_STATUS_EN
  modport master (
    output in_valid, in_ch, in_sop, in_code,
    output load_en, load_ch, load_pred, load_index,
    output out_ready,
    input  in_ready, out_valid, out_ch, out_sample, out_sat, err_ch
  );
  modport slave (
    input  in_valid, in_ch, in_sop, in_code,
    input  load_en, load_ch, load_pred, load_index,
    input  out_ready,
    output in_ready, out_valid, out_ch, out_sample, out_sat, err_ch
  );
`else
  modport master (
    output in_valid, in_ch, in_sop, in_code,
    output load_en, load_ch, load_pred, load_index,
    output out_ready,
    input  in_ready, out_valid, out_ch, out_sample
  );
  modport slave (
    input  in_valid, in_ch, in_sop, in_code,
    input  load_en, load_ch, load_pred, load_index,
    input  out_ready,
    output in_ready, out_valid, out_ch, out_sample
  );
`endif
endinterface

// File: rtl/ima_adpcm_decoder_mc.sv
// Multi-channel IMA ADPCM decoder with per-channel predictor/step-index state,
// header preload, and a single registered output stage (no throughput bubble).
// Optional macro ADPCM_STATUS_EN adds out_sat and err_ch status outputs.
module ima_adpcm_decoder_mc #(
  parameter int NUM_CH = 4,
  parameter int OUT_W  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  ima_adpcm_decoder_mc_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  localparam logic [14:0] STEP_TABLE [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  logic signed [15:0] pred_mem [NUM_CH];
  logic [6:0]         idx_mem  [NUM_CH];

  logic               accept, ch_ok, load_ok, sat;
  logic [CH_W-1:0]    rd_ch;
  logic signed [15:0] cur_pred, pred_nxt;
  logic [6:0]         cur_idx, idx_nxt;
  logic [2:0]         adj_q;
  logic [19:0]        prod;
  logic signed [19:0] t_s, diff, sum;
  logic signed [7:0]  idx_sum;
  logic [OUT_W-1:0]   sample_w;

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.load_en && rst_n;
  assign accept       = bus.in_valid && bus.in_ready;
  assign ch_ok        = {1'b0, bus.in_ch} < NUM_CH_L;
  assign load_ok      = {1'b0, bus.load_ch} < NUM_CH_L;
  // Out-of-range channels read a harmless entry; their result is discarded.
  assign rd_ch        = ch_ok ? bus.in_ch : '0;

  // Decode one code against the addressed channel's (or a fresh) state.
  always_comb begin
    cur_pred = bus.in_sop ? '0 : pred_mem[rd_ch];
    cur_idx  = bus.in_sop ? '0 : idx_mem[rd_ch];
    prod     = {5'd0, STEP_TABLE[cur_idx]} * {16'd0, bus.in_code[2:0], 1'b1};
    t_s      = bus.in_code[3] ? -$signed(prod) : $signed(prod);
    diff     = t_s >>> 3;
    // Sum is kept wider than 17 bits so the clamp sees the true value.
    sum      = {{4{cur_pred[15]}}, cur_pred} + diff;
    sat      = 1'b0;
    pred_nxt = sum[15:0];
    if (sum > 20'sd32767) begin
      pred_nxt = 16'h7FFF;
      sat      = 1'b1;
    end else if (sum < -20'sd32768) begin
      pred_nxt = 16'h8000;
      sat      = 1'b1;
    end
    adj_q   = {1'b0, bus.in_code[1:0]} + 3'd1;
    idx_sum = $signed({1'b0, cur_idx})
            + (bus.in_code[2] ? $signed({4'd0, adj_q, 1'b0}) : -8'sd1);
    if (idx_sum < 8'sd0)       idx_nxt = 7'd0;
    else if (idx_sum > 8'sd88) idx_nxt = 7'd88;
    else                       idx_nxt = idx_sum[6:0];
    sample_w = OUT_W'($unsigned(pred_nxt)) << (OUT_W - 16);
  end

  // Channel state update, preload, and the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_mem       <= '{default: '0};
      idx_mem        <= '{default: '0};
      bus.out_valid  <= 1'b0;
      bus.out_ch     <= '0;
      bus.out_sample <= '0;
`ifdef ADPCM_STATUS_EN
      bus.out_sat    <= 1'b0;
      bus.err_ch     <= 1'b0;
`endif
    end else begin
      if (accept && ch_ok) begin
        pred_mem[bus.in_ch] <= pred_nxt;
        idx_mem[bus.in_ch]  <= idx_nxt;
        bus.out_valid       <= 1'b1;
        bus.out_ch          <= bus.in_ch;
        bus.out_sample      <= sample_w;
`ifdef ADPCM_STATUS_EN
        bus.out_sat         <= sat;
`endif
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (bus.load_en && load_ok) begin
        pred_mem[bus.load_ch] <= bus.load_pred;
        idx_mem[bus.load_ch]  <= (bus.load_index > 7'd88) ? 7'd88 : bus.load_index;
      end
`ifdef ADPCM_STATUS_EN
      bus.err_ch <= accept && !ch_ok;
`endif
    end
  end
endmodule
